frame_conditioner: RTL

Downstream consumer of the 16-sample microphone frame (sixteen 18-bit unsigned samples, raw 12-bit ADC codes left-shifted by 6, plus a frame-complete level). It captures each new frame, removes the frame's DC mean, applies a 16-point periodic Hann window, and streams the 16 conditioned signed samples through a valid/ready port to the spectrum (FFT) stage. Frames that arrive while a frame is still being processed are dropped and counted.

---
 rtl/frame_pkg.sv | 26 ++
 rtl/frame_window_mac.sv | 35 +++
 rtl/frame_conditioner.sv | 135 +++++++++++++
 3 files changed

// File: rtl/frame_pkg.sv
// rtl/frame_pkg.sv - shared widths, FSM states and Hann window table for frame_conditioner
package frame_pkg;

    localparam int N      = 16;
    localparam int IN_W   = 18;
    localparam int OUT_W  = 18;
    localparam int ACC_W  = IN_W + 4;
    localparam int HANN_W = 16;
    localparam int IDX_W  = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        LOAD  = 2'd2,
        EMIT  = 2'd3
    } state_e;

    // 16-point periodic Hann window, unsigned Q1.15
    localparam logic [HANN_W-1:0] HANN [N] = '{
        16'd0,     16'd1247,  16'd4799,  16'd10114,
        16'd16384, 16'd22654, 16'd27969, 16'd31521,
        16'd32767, 16'd31521, 16'd27969, 16'd22654,
        16'd16384, 16'd10114, 16'd4799,  16'd1247
    };

endpackage

// File: rtl/frame_window_mac.sv
// rtl/frame_window_mac.sv - combinational mean removal, Hann weighting and saturation of one sample
module frame_window_mac
    import frame_pkg::*;
(
    input  logic [IN_W-1:0]   sample,
    input  logic [IN_W-1:0]   mean,
    input  logic [HANN_W-1:0] coef,
    output logic [OUT_W-1:0]  cond
);

    localparam int PROD_W = IN_W + HANN_W + 2;
    localparam int SAT_MAX = (1 << (OUT_W - 1)) - 1;
    localparam int SAT_MIN = -(1 << (OUT_W - 1));
    localparam logic signed [PROD_W-1:0] SAT_HI = PROD_W'(SAT_MAX);
    localparam logic signed [PROD_W-1:0] SAT_LO = PROD_W'(SAT_MIN);

    logic signed [IN_W:0]     diff;
    logic signed [PROD_W-1:0] prod;
    logic signed [PROD_W-1:0] shifted;

    always_comb begin
        diff    = $signed({1'b0, sample}) - $signed({1'b0, mean});
        prod    = PROD_W'(diff) * PROD_W'($signed({1'b0, coef}));
        // arithmetic shift floors toward minus infinity
        shifted = prod >>> 15;
        if (shifted > SAT_HI) begin
            cond = SAT_HI[OUT_W-1:0];
        end else if (shifted < SAT_LO) begin
            cond = SAT_LO[OUT_W-1:0];
        end else begin
            cond = shifted[OUT_W-1:0];
        end
    end

endmodule

// File: rtl/frame_conditioner.sv
// rtl/frame_conditioner.sv - captures a 16-sample frame, removes DC, applies Hann window, streams results
module frame_conditioner
    import frame_pkg::*;
(
    input  logic                clk_25,
    input  logic                rst_n,
    input  logic                frame_valid,
    input  logic [N*IN_W-1:0]   frame_in,
    output logic [OUT_W-1:0]    out_data,
    output logic [IDX_W-1:0]    out_index,
    output logic                out_last,
    output logic                out_valid,
    input  logic                out_ready,
    output logic                busy,
    output logic [7:0]          overrun_cnt
);

    state_e              state_q, state_d;
    logic                fv_q, fv_d;
    logic [IN_W-1:0]     buf_q [N];
    logic [IN_W-1:0]     buf_d [N];
    logic [ACC_W-1:0]    acc_q, acc_d;
    logic [IDX_W-1:0]    cnt_q, cnt_d;
    logic [IN_W-1:0]     mean_q, mean_d;
    logic [OUT_W-1:0]    out_data_q, out_data_d;
    logic [IDX_W-1:0]    out_index_q, out_index_d;
    logic                out_valid_q, out_valid_d;
    logic [7:0]          ovr_q, ovr_d;

    logic                new_frame;
    logic [IDX_W-1:0]    sel_idx;
    logic [OUT_W-1:0]    mac_cond;

    // LOAD always prepares sample 0; EMIT prepares the one after the sample on the port
    assign sel_idx = (state_q == EMIT) ? out_index_q + 4'd1 : '0;

    frame_window_mac u_mac (
        .sample (buf_q[sel_idx]),
        .mean   (mean_q),
        .coef   (HANN[sel_idx]),
        .cond   (mac_cond)
    );

    always_comb begin
        state_d     = state_q;
        fv_d        = frame_valid;
        buf_d       = buf_q;
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        mean_d      = mean_q;
        out_data_d  = out_data_q;
        out_index_d = out_index_q;
        out_valid_d = out_valid_q;
        ovr_d       = ovr_q;

        new_frame = frame_valid && !fv_q;

        if (new_frame && (state_q != IDLE) && (ovr_q != 8'hff)) begin
            ovr_d = ovr_q + 8'd1;
        end

        case (state_q)
            IDLE: begin
                if (new_frame) begin
                    for (int k = 0; k < N; k++) begin
                        buf_d[k] = frame_in[k*IN_W +: IN_W];
                    end
                    acc_d   = '0;
                    cnt_d   = '0;
                    state_d = ACCUM;
                end
            end
            ACCUM: begin
                acc_d = acc_q + ACC_W'(buf_q[cnt_q]);
                cnt_d = cnt_q + 4'd1;
                if (cnt_q == 4'd15) begin
                    mean_d  = acc_d[ACC_W-1:4];
                    state_d = LOAD;
                end
            end
            LOAD: begin
                out_data_d  = mac_cond;
                out_index_d = '0;
                out_valid_d = 1'b1;
                state_d     = EMIT;
            end
            EMIT: begin
                if (out_valid_q && out_ready) begin
                    if (out_index_q != 4'd15) begin
                        out_data_d  = mac_cond;
                        out_index_d = out_index_q + 4'd1;
                    end else begin
                        out_valid_d = 1'b0;
                        state_d     = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_25 or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            fv_q        <= 1'b0;
            buf_q       <= '{default: '0};
            acc_q       <= '0;
            cnt_q       <= '0;
            mean_q      <= '0;
            out_data_q  <= '0;
            out_index_q <= '0;
            out_valid_q <= 1'b0;
            ovr_q       <= '0;
        end else begin
            state_q     <= state_d;
            fv_q        <= fv_d;
            buf_q       <= buf_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            mean_q      <= mean_d;
            out_data_q  <= out_data_d;
            out_index_q <= out_index_d;
            out_valid_q <= out_valid_d;
            ovr_q       <= ovr_d;
        end
    end

    assign out_data    = out_data_q;
    assign out_index   = out_index_q;
    assign out_valid   = out_valid_q;
    assign out_last    = out_valid_q && (out_index_q == 4'd15);
    assign busy        = (state_q != IDLE);
    assign overrun_cnt = ovr_q;

endmodule
